// File: rtl/uart_loader.sv
// uart_loader: host-facing monitor / boot loader for the cpu core.
//
// Parses a byte command stream from the UART receiver:
//   'L' ADDR_HI ADDR_LO LEN data...  -> writes LEN bytes (0 means 256) into RAM,
//                                       replies 'K' followed by the 8-bit byte sum.
//   'G' ADDR_HI ADDR_LO              -> pulses cpu_start at that address, then waits
//                                       for cpu_halted and replies 'H'.
//   anything else while idle         -> replies '?'.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   received, rx_byte    one-cycle "new byte" pulse and the byte itself
//   is_transmitting      UART transmitter busy
//   tx_byte, transmit    byte to send and its one-cycle send request
//   l_waddr, l_dwrite,
//   l_write_en           RAM write port (one-cycle strobe)
//   cpu_start,
//   cpu_startaddr        one-cycle start pulse and start address for the cpu
//   cpu_halted           one-cycle halt pulse from the cpu
//   running              high from cpu_start until the halt is seen
module uart_loader #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    output logic [addr_width-1:0] l_waddr,
    output logic [7:0]            l_dwrite,
    output logic                  l_write_en,
    output logic                  cpu_start,
    output logic [addr_width-1:0] cpu_startaddr,
    input  logic                  cpu_halted,
    output logic                  running
);
    typedef logic [addr_width-1:0] addr_t;
    localparam addr_t ADDR_ONE = addr_t'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_L_AH, S_L_AL, S_L_LEN, S_L_DATA,
        S_G_AH, S_G_AL, S_GSTART, S_RUN, S_REPLY, S_TXGAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_hi_q, addr_hi_d;
    addr_t      load_addr_q, load_addr_d;      // address of the next data byte
    logic [8:0] count_q, count_d;              // data bytes still expected (1..256)
    logic [7:0] checksum_q, checksum_d;
    logic [7:0] tx_byte_q, tx_byte_d;          // reply byte at the head of the queue
    logic [7:0] reply2_q, reply2_d;            // second reply byte, if any
    logic [1:0] reply_cnt_q, reply_cnt_d;      // reply bytes not yet sent
    addr_t      l_waddr_q, l_waddr_d;
    logic [7:0] l_dwrite_q, l_dwrite_d;
    logic       l_write_en_q, l_write_en_d;
    logic       cpu_start_q, cpu_start_d;
    addr_t      cpu_startaddr_q, cpu_startaddr_d;
    logic       running_q, running_d;
    logic [7:0] sum_next;

    // State register (and datapath registers).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_hi_q       <= '0;
            load_addr_q     <= '0;
            count_q         <= '0;
            checksum_q      <= '0;
            tx_byte_q       <= '0;
            reply2_q        <= '0;
            reply_cnt_q     <= '0;
            l_waddr_q       <= '0;
            l_dwrite_q      <= '0;
            l_write_en_q    <= 1'b0;
            cpu_start_q     <= 1'b0;
            cpu_startaddr_q <= '0;
            running_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_hi_q       <= addr_hi_d;
            load_addr_q     <= load_addr_d;
            count_q         <= count_d;
            checksum_q      <= checksum_d;
            tx_byte_q       <= tx_byte_d;
            reply2_q        <= reply2_d;
            reply_cnt_q     <= reply_cnt_d;
            l_waddr_q       <= l_waddr_d;
            l_dwrite_q      <= l_dwrite_d;
            l_write_en_q    <= l_write_en_d;
            cpu_start_q     <= cpu_start_d;
            cpu_startaddr_q <= cpu_startaddr_d;
            running_q       <= running_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d         = state_q;
        addr_hi_d       = addr_hi_q;
        load_addr_d     = load_addr_q;
        count_d         = count_q;
        checksum_d      = checksum_q;
        tx_byte_d       = tx_byte_q;
        reply2_d        = reply2_q;
        reply_cnt_d     = reply_cnt_q;
        l_waddr_d       = l_waddr_q;
        l_dwrite_d      = l_dwrite_q;
        l_write_en_d    = 1'b0;
        cpu_start_d     = 1'b0;
        cpu_startaddr_d = cpu_startaddr_q;
        running_d       = running_q;
        sum_next        = checksum_q + rx_byte;

        case (state_q)
            S_IDLE: if (received) begin
                if (rx_byte == 8'h4C)      state_d = S_L_AH;
                else if (rx_byte == 8'h47) state_d = S_G_AH;
                else begin
                    tx_byte_d   = 8'h3F;
                    reply_cnt_d = 2'd1;
                    state_d     = S_REPLY;
                end
            end
            S_L_AH: if (received) begin
                addr_hi_d = rx_byte;
                state_d   = S_L_AL;
            end
            S_L_AL: if (received) begin
                // Truncation drops address bits beyond the RAM size.
                load_addr_d = addr_t'({addr_hi_q, rx_byte});
                state_d     = S_L_LEN;
            end
            S_L_LEN: if (received) begin
                count_d    = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                checksum_d = 8'd0;
                state_d    = S_L_DATA;
            end
            S_L_DATA: if (received) begin
                l_write_en_d = 1'b1;
                l_dwrite_d   = rx_byte;
                l_waddr_d    = load_addr_q;
                load_addr_d  = load_addr_q + ADDR_ONE;   // wraps naturally
                checksum_d   = sum_next;
                count_d      = count_q - 9'd1;
                if (count_q == 9'd1) begin
                    tx_byte_d   = 8'h4B;
                    reply2_d    = sum_next;
                    reply_cnt_d = 2'd2;
                    state_d     = S_REPLY;
                end
            end
            S_G_AH: if (received) begin
                addr_hi_d = rx_byte;
                state_d   = S_G_AL;
            end
            S_G_AL: if (received) begin
                cpu_startaddr_d = addr_t'({addr_hi_q, rx_byte});
                state_d         = S_GSTART;
            end
            S_GSTART: begin
                // cpu_halted is deliberately not looked at here.
                cpu_start_d = 1'b1;
                running_d   = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: if (cpu_halted) begin
                running_d   = 1'b0;
                tx_byte_d   = 8'h48;
                reply_cnt_d = 2'd1;
                state_d     = S_REPLY;
            end
            S_REPLY: if (!is_transmitting) begin
                // transmit fires this cycle; advance the queue behind it.
                reply_cnt_d = reply_cnt_q - 2'd1;
                if (reply_cnt_q == 2'd2) tx_byte_d = reply2_q;
                state_d = S_TXGAP;
            end
            // One dead cycle lets the transmitter raise is_transmitting.
            S_TXGAP: state_d = (reply_cnt_q != 2'd0) ? S_REPLY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. transmit is decoded from the state so the first reply byte
    // leaves in the cycle right after the byte that triggered it.
    always_comb begin
        transmit      = (state_q == S_REPLY) && !is_transmitting;
        tx_byte       = tx_byte_q;
        l_waddr       = l_waddr_q;
        l_dwrite      = l_dwrite_q;
        l_write_en    = l_write_en_q;
        cpu_start     = cpu_start_q;
        cpu_startaddr = cpu_startaddr_q;
        running       = running_q;
    end
endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader (addr_width = 9).
module tb_uart_loader;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          received = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          is_transmitting = 1'b0;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic [AW-1:0] l_waddr;
    logic [7:0]    l_dwrite;
    logic          l_write_en;
    logic          cpu_start;
    logic [AW-1:0] cpu_startaddr;
    logic          cpu_halted = 1'b0;
    logic          running;

    uart_loader #(.addr_width(AW)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
        .l_waddr(l_waddr), .l_dwrite(l_dwrite), .l_write_en(l_write_en),
        .cpu_start(cpu_start), .cpu_startaddr(cpu_startaddr),
        .cpu_halted(cpu_halted), .running(running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe/pulse observed is logged with its cycle number.
    int          w_cyc[$];
    logic [15:0] w_addr[$];
    logic [7:0]  w_data[$];
    int          tx_cyc[$];
    logic [7:0]  tx_q[$];
    int          st_cyc[$];
    int          busy_viol = 0;

    always @(negedge clk) begin
        if (l_write_en) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(16'(l_waddr));
            w_data.push_back(l_dwrite);
        end
        if (transmit) begin
            tx_cyc.push_back(cyc);
            tx_q.push_back(tx_byte);
            if (is_transmitting) busy_viol++;
        end
        if (cpu_start) st_cyc.push_back(cyc);
    end

    // One command and its expected effects. Lists are MSB-first.
    typedef struct {
        int          n;       // command bytes
        logic [63:0] cmd;
        int          nw;      // expected RAM writes
        logic [63:0] waddr;
        logic [31:0] wdata;
        int          ntx;     // expected reply bytes
        logic [15:0] tx;
    } vec_t;

    vec_t vecs[8];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   last_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        tx_cyc.delete(); tx_q.delete(); st_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        received = 1'b1;
        rx_byte  = b;
        last_c   = cyc;
        @(posedge clk); #1;
        received = 1'b0;
    endtask

    task automatic pulse_halt();
        @(posedge clk); #1 cpu_halted = 1'b1;
        @(posedge clk); #1 cpu_halted = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        clear_mon();
        for (int i = 0; i < v.n; i++) send_byte(v.cmd[63-8*i -: 8]);
        idle(12);
        chk($sformatf("v%0d nwrites", idx), 32'(w_addr.size()), 32'(v.nw));
        for (int i = 0; i < v.nw; i++) begin
            if (i < w_addr.size()) begin
                chk($sformatf("v%0d waddr%0d", idx, i), 32'(w_addr[i]), 32'(v.waddr[63-16*i -: 16]));
                chk($sformatf("v%0d wdata%0d", idx, i), 32'(w_data[i]), 32'(v.wdata[31-8*i -: 8]));
            end
        end
        if (v.nw > 0 && w_cyc.size() > 0)
            chk($sformatf("v%0d wlat", idx), 32'(w_cyc[w_cyc.size()-1] - last_c), 32'd1);
        chk($sformatf("v%0d ntx", idx), 32'(tx_q.size()), 32'(v.ntx));
        for (int i = 0; i < v.ntx; i++) begin
            if (i < tx_q.size())
                chk($sformatf("v%0d tx%0d", idx, i), 32'(tx_q[i]), 32'(v.tx[15-8*i -: 8]));
        end
        if (v.ntx > 0 && tx_cyc.size() > 0)
            chk($sformatf("v%0d txlat", idx), 32'(tx_cyc[0] - last_c), 32'd1);
        $display("vector %0d: %0d cmd bytes, %0d writes, %0d tx bytes", idx, v.n, w_addr.size(), tx_q.size());
    endtask

    initial begin
        // Load at 0x010; sum AA+BB+CC = 0x231 -> 0x31.
        vecs[0] = '{n:7, cmd:64'h4C_00_10_03_AA_BB_CC_00, nw:3,
                    waddr:64'h0010_0011_0012_0000, wdata:32'hAA_BB_CC_00, ntx:2, tx:16'h4B_31};
        // Address wrap 0x1FF -> 0x000.
        vecs[1] = '{n:6, cmd:64'h4C_01_FF_02_11_22_00_00, nw:2,
                    waddr:64'h01FF_0000_0000_0000, wdata:32'h11_22_00_00, ntx:2, tx:16'h4B_33};
        vecs[2] = '{n:1, cmd:64'h55_00_00_00_00_00_00_00, nw:0,
                    waddr:64'h0, wdata:32'h0, ntx:1, tx:16'h3F_00};
        // Excess address bits: 0xFE05 -> 0x005.
        vecs[3] = '{n:5, cmd:64'h4C_FE_05_01_7E_00_00_00, nw:1,
                    waddr:64'h0005_0000_0000_0000, wdata:32'h7E_00_00_00, ntx:2, tx:16'h4B_7E};
        vecs[4] = '{n:1, cmd:64'h6C_00_00_00_00_00_00_00, nw:0,
                    waddr:64'h0, wdata:32'h0, ntx:1, tx:16'h3F_00};
        // Checksum wrap: FF+02 = 0x01.
        vecs[5] = '{n:6, cmd:64'h4C_00_00_02_FF_02_00_00, nw:2,
                    waddr:64'h0000_0001_0000_0000, wdata:32'hFF_02_00_00, ntx:2, tx:16'h4B_01};
        vecs[6] = '{n:5, cmd:64'h4C_00_40_01_7E_00_00_00, nw:1,
                    waddr:64'h0040_0000_0000_0000, wdata:32'h7E_00_00_00, ntx:2, tx:16'h4B_7E};
        vecs[7] = '{n:5, cmd:64'h4C_00_02_01_5A_00_00_00, nw:1,
                    waddr:64'h0002_0000_0000_0000, wdata:32'h5A_00_00_00, ntx:2, tx:16'h4B_5A};

        // Reset state.
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst transmit", 32'(transmit), 32'd0);
        chk("rst tx_byte", 32'(tx_byte), 32'd0);
        chk("rst l_write_en", 32'(l_write_en), 32'd0);
        chk("rst l_waddr", 32'(l_waddr), 32'd0);
        chk("rst l_dwrite", 32'(l_dwrite), 32'd0);
        chk("rst cpu_start", 32'(cpu_start), 32'd0);
        chk("rst cpu_startaddr", 32'(cpu_startaddr), 32'd0);
        chk("rst running", 32'(running), 32'd0);
        $display("reset: outputs checked");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // LEN=0 -> 256 bytes starting at 0x180, wrapping to end at 0x07F.
        // Sum of 0..255 = 32640 = 0x7F80 -> checksum 0x80.
        clear_mon();
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'h80); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        idle(10);
        chk("len0 nwrites", 32'(w_addr.size()), 32'd256);
        if (w_addr.size() == 256) begin
            chk("len0 first addr", 32'(w_addr[0]), 32'h180);
            chk("len0 last addr", 32'(w_addr[255]), 32'h07F);
            chk("len0 last data", 32'(w_data[255]), 32'hFF);
        end
        chk("len0 ntx", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() == 2) begin
            chk("len0 tx0", 32'(tx_q[0]), 32'h4B);
            chk("len0 tx1", 32'(tx_q[1]), 32'h80);
        end
        $display("len0: %0d writes, %0d tx bytes", w_addr.size(), tx_q.size());

        // Go / halt; RX ignored while running.
        clear_mon();
        send_byte(8'h47); send_byte(8'h01); send_byte(8'h20);
        idle(3);
        chk("go startaddr", 32'(cpu_startaddr), 32'h120);
        chk("go nstart", 32'(st_cyc.size()), 32'd1);
        if (st_cyc.size() > 0) chk("go start lat", 32'(st_cyc[0] - last_c), 32'd2);
        chk("go running", 32'(running), 32'd1);
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h99);
        idle(5);
        chk("run nwrites", 32'(w_addr.size()), 32'd0);
        chk("run ntx", 32'(tx_q.size()), 32'd0);
        chk("run running", 32'(running), 32'd1);
        pulse_halt();
        chk("halt running", 32'(running), 32'd0);
        idle(5);
        chk("halt ntx", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("halt tx", 32'(tx_q[0]), 32'h48);
        $display("go/halt: start at %0h, %0d tx bytes", cpu_startaddr, tx_q.size());

        // cpu_halted coinciding with GSTART is ignored.
        clear_mon();
        send_byte(8'h47); send_byte(8'h00); send_byte(8'h05);
        cpu_halted = 1'b1;
        @(posedge clk); #1 cpu_halted = 1'b0;
        idle(5);
        chk("gstart halt running", 32'(running), 32'd1);
        chk("gstart halt ntx", 32'(tx_q.size()), 32'd0);
        chk("gstart startaddr", 32'(cpu_startaddr), 32'h005);
        pulse_halt();
        idle(5);
        chk("gstart2 running", 32'(running), 32'd0);
        chk("gstart2 ntx", 32'(tx_q.size()), 32'd1);
        $display("gstart-halt: running=%0d, %0d tx bytes", running, tx_q.size());

        // Busy transmitter stalls '?'; a byte arriving during REPLY is dropped.
        clear_mon();
        is_transmitting = 1'b1;
        send_byte(8'h55);
        idle(1);
        send_byte(8'h47);
        idle(8);
        chk("busy ntx", 32'(tx_q.size()), 32'd0);
        is_transmitting = 1'b0;
        idle(6);
        chk("release ntx", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("release tx", 32'(tx_q[0]), 32'h3F);
        chk("busy violations", 32'(busy_viol), 32'd0);
        $display("busy: %0d tx bytes after release", tx_q.size());
        run_vec(vecs[7], 7);

        // Reset in the middle of a load.
        clear_mon();
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h02);
        idle(1);
        chk("midload nwrites", 32'(w_addr.size()), 32'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_mon();
        chk("midrst l_waddr", 32'(l_waddr), 32'd0);
        chk("midrst l_dwrite", 32'(l_dwrite), 32'd0);
        idle(10);
        chk("midrst nwrites", 32'(w_addr.size()), 32'd0);
        chk("midrst ntx", 32'(tx_q.size()), 32'd0);
        $display("reset mid-load: %0d writes, %0d tx after reset", w_addr.size(), tx_q.size());
        run_vec(vecs[6], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
